// File: rtl/ro_puf_engine.sv
// ro_puf_engine: ring-oscillator PUF response engine; selects one RO per bank per bit,
// counts synchronised rising edges over a fixed window and compares the two counts.
module ro_puf_engine #(
  parameter int RO_NO      = 256,
  parameter int SEL_W      = 8,
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 16,
  parameter int RESP_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEL_W-1:0]     chall0,
  input  logic [SEL_W-1:0]     chall1,
  input  logic [RO_NO-1:0]     ro_out0,
  input  logic [RO_NO-1:0]     ro_out1,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [RESP_BITS-1:0] tie_mask,
  output logic [CNT_W-1:0]     last_cnt0,
  output logic [CNT_W-1:0]     last_cnt1
);
  localparam int KW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
  localparam int TW = $clog2((WIN_CYC > SETTLE_CYC ? WIN_CYC : SETTLE_CYC) + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, DONE} state_t;
  state_t st;
  logic [KW-1:0] k;
  logic [SEL_W-1:0] c0_lat, c1_lat, sel0, sel1, nsel0, nsel1;
  logic [TW-1:0] tmr;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic [1:0] sync0, sync1;
  logic sync0_d, sync1_d, edge0, edge1, load, samp0, samp1, last_bit, set_end, win_end;
  assign sel0 = c0_lat + SEL_W'(k);
  assign sel1 = c1_lat + SEL_W'(k);
  assign nsel0 = st == IDLE ? chall0 : sel0 + SEL_W'(1);
  assign nsel1 = st == IDLE ? chall1 : sel1 + SEL_W'(1);
  // On entry to SETTLE the first flop already samples the next RO, so the
  // pipeline holds three real samples by the first COUNT cycle.
  assign load = (st == IDLE && start) || (st == COMPARE && !last_bit);
  assign samp0 = ro_out0[load ? nsel0 : sel0];
  assign samp1 = ro_out1[load ? nsel1 : sel1];
  assign edge0 = sync0[1] & ~sync0_d;
  assign edge1 = sync1[1] & ~sync1_d;
  assign last_bit = k == KW'(RESP_BITS - 1);
  assign set_end = tmr == TW'(SETTLE_CYC - 1);
  assign win_end = tmr == TW'(WIN_CYC - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      k <= '0;
      c0_lat <= '0;
      c1_lat <= '0;
      tmr <= '0;
      cnt0 <= '0;
      cnt1 <= '0;
      sync0 <= '0;
      sync1 <= '0;
      sync0_d <= 1'b0;
      sync1_d <= 1'b0;
      ro_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      response <= '0;
      tie_mask <= '0;
      last_cnt0 <= '0;
      last_cnt1 <= '0;
    end else begin
      sync0 <= load ? {1'b0, samp0} : {sync0[0], samp0};
      sync1 <= load ? {1'b0, samp1} : {sync1[0], samp1};
      sync0_d <= load ? 1'b0 : sync0[1];
      sync1_d <= load ? 1'b0 : sync1[1];
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          c0_lat <= chall0;
          c1_lat <= chall1;
          k <= '0;
          response <= '0;
          tie_mask <= '0;
          tmr <= '0;
          cnt0 <= '0;
          cnt1 <= '0;
          busy <= 1'b1;
          ro_en <= 1'b1;
          st <= SETTLE;
        end
        SETTLE: begin
          cnt0 <= '0;
          cnt1 <= '0;
          tmr <= set_end ? '0 : tmr + TW'(1);
          st <= set_end ? COUNT : SETTLE;
        end
        COUNT: begin
          if (edge0 && !(&cnt0)) cnt0 <= cnt0 + CNT_W'(1);
          if (edge1 && !(&cnt1)) cnt1 <= cnt1 + CNT_W'(1);
          tmr <= win_end ? '0 : tmr + TW'(1);
          ro_en <= !win_end;
          st <= win_end ? COMPARE : COUNT;
        end
        COMPARE: begin
          response[k] <= cnt0 > cnt1;
          tie_mask[k] <= cnt0 == cnt1;
          last_cnt0 <= cnt0;
          last_cnt1 <= cnt1;
          if (last_bit) begin
            done <= 1'b1;
            st <= DONE;
          end else begin
            k <= k + KW'(1);
            cnt0 <= '0;
            cnt1 <= '0;
            tmr <= '0;
            ro_en <= 1'b1;
            st <= SETTLE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ro_puf_engine.sv
// tb_ro_puf_engine: directed checks of the RO PUF engine with clk-aligned synthetic RO waveforms.
module tb_ro_puf_engine;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0] chall0 = '0, chall1 = '0;
  logic [3:0] ro_out0 = '0, ro_out1 = '0;
  logic ro_en, busy, done, ro_en_s, busy_s, done_s;
  logic [1:0] response, tie_mask, response_s, tie_mask_s;
  logic [7:0] last_cnt0, last_cnt1;
  logic [1:0] last_cnt0_s, last_cnt1_s;
  int hp0[4] = '{default: 0};
  int hp1[4] = '{default: 0};
  int tcnt = 0;
  int n_chk = 0, n_pass = 0;
  int lat, nd, t1, t2;

  ro_puf_engine #(.RO_NO(4), .SEL_W(2), .CNT_W(8), .WIN_CYC(16), .SETTLE_CYC(2), .RESP_BITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .chall0(chall0), .chall1(chall1),
    .ro_out0(ro_out0), .ro_out1(ro_out1), .ro_en(ro_en), .busy(busy), .done(done),
    .response(response), .tie_mask(tie_mask), .last_cnt0(last_cnt0), .last_cnt1(last_cnt1));

  ro_puf_engine #(.RO_NO(4), .SEL_W(2), .CNT_W(2), .WIN_CYC(16), .SETTLE_CYC(2), .RESP_BITS(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .chall0(chall0), .chall1(chall1),
    .ro_out0(ro_out0), .ro_out1(ro_out1), .ro_en(ro_en_s), .busy(busy_s), .done(done_s),
    .response(response_s), .tie_mask(tie_mask_s), .last_cnt0(last_cnt0_s), .last_cnt1(last_cnt1_s));

  always #5 clk = ~clk;

  // half-period in clk cycles per RO; 0 keeps the RO static low
  always @(negedge clk) begin
    tcnt++;
    for (int i = 0; i < 4; i++) begin
      ro_out0[i] = hp0[i] == 0 ? 1'b0 : 1'((tcnt / hp0[i]) % 2);
      ro_out1[i] = hp1[i] == 0 ? 1'b0 : 1'((tcnt / hp1[i]) % 2);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_hp(input int a0, a1, a2, a3, b0, b1, b2, b3);
    hp0 = '{a0, a1, a2, a3};
    hp1 = '{b0, b1, b2, b3};
  endtask

  task automatic run(input logic [1:0] c0, input logic [1:0] c1, input int extra_at,
                     output int l, output int n_done);
    chall0 = c0;
    chall1 = c1;
    start = 1'b1;
    l = -1;
    n_done = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = (n == extra_at);
      if (n == 1) begin
        chall0 = ~c0;
        chall1 = ~c1;
        check("busy_run", busy, 1);
        check("ro_en_settle", ro_en, 1);
      end
      if (n == 19) check("ro_en_compare", ro_en, 0);
      if (done) begin
        n_done++;
        if (l < 0) l = n;
      end
    end
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #1;
    check("rst_ro_en", ro_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_response", response, 0);
    check("rst_tie", tie_mask, 0);
    check("rst_cnt0", last_cnt0, 0);
    check("rst_cnt1", last_cnt1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    set_hp(2, 2, 2, 2, 4, 4, 4, 4);
    run(2'd0, 2'd0, 0, lat, nd);
    check("basic_latency", lat, 39);
    check("basic_ndone", nd, 1);
    check("basic_response", response, 2'b11);
    check("basic_tie", tie_mask, 0);
    check("basic_cnt0", last_cnt0, 4);
    check("basic_cnt1", last_cnt1, 2);

    set_hp(2, 1, 1, 4, 1, 2, 4, 1);
    run(2'd3, 2'd1, 0, lat, nd);
    check("wrap_latency", lat, 39);
    check("wrap_response", response, 2'b10);
    check("wrap_tie", tie_mask, 0);
    check("wrap_cnt0", last_cnt0, 4);
    check("wrap_cnt1", last_cnt1, 2);

    set_hp(2, 2, 2, 2, 2, 2, 2, 2);
    run(2'd1, 2'd2, 0, lat, nd);
    check("tie_response", response, 0);
    check("tie_mask", tie_mask, 2'b11);
    check("tie_cnt0", last_cnt0, 4);
    check("tie_cnt1", last_cnt1, 4);

    set_hp(1, 1, 1, 1, 0, 0, 0, 0);
    run(2'd0, 2'd0, 0, lat, nd);
    check("sat_wide_cnt0", last_cnt0, 8);
    check("sat_cnt0", last_cnt0_s, 3);
    check("sat_cnt1", last_cnt1_s, 0);
    check("sat_response", response_s, 2'b11);
    check("sat_tie", tie_mask_s, 0);

    set_hp(2, 2, 2, 2, 4, 4, 4, 4);
    run(2'd0, 2'd0, 8, lat, nd);
    check("busy_ignore_latency", lat, 39);
    check("busy_ignore_ndone", nd, 1);

    start = 1'b1;
    nd = 0;
    t1 = -1;
    t2 = -1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) t1 = n;
        if (nd == 2) begin
          t2 = n;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("hold_first_done", t1, 39);
    check("hold_second_done", t2, 79);
    check("hold_response", response, 2'b11);

    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_ro_en", ro_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_response", response, 0);
    check("mid_rst_cnt0", last_cnt0, 0);
    check("mid_rst_cnt1", last_cnt1, 0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("mid_rst_no_done", nd, 0);
    run(2'd0, 2'd0, 0, lat, nd);
    check("after_rst_latency", lat, 39);
    check("after_rst_response", response, 2'b11);
    check("after_rst_cnt0", last_cnt0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ro_puf_engine.md
Name: ro_puf_engine

Overview:
- Parametrised ring-oscillator PUF response engine.
- Selects one RO from each of two banks per response bit and counts rising edges of both over a fixed window, then compares the counts to produce one response bit.
- Repeats for RESP_BITS consecutive challenge offsets.
- Sits between the two RO banks (instantiated outside) and the system controller; drives the bank enable and replaces the separate mux/counter/controller arrangement.

Parameters:
- RO_NO, 256, ROs per bank; must equal 2**SEL_W.
- SEL_W, 8, challenge select width.
- CNT_W, 16, edge counter width.
- WIN_CYC, 1024, counting window length in clk cycles (>=1).
- SETTLE_CYC, 16, RO settle cycles before each window (>=1).
- RESP_BITS, 8, response bits generated per start.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a response; sampled only in IDLE.
- chall0  in  SEL_W  bank-0 base select; sampled with start.
- chall1  in  SEL_W  bank-1 base select; sampled with start.
- ro_out0  in  RO_NO  bank-0 RO outputs, asynchronous to clk.
- ro_out1  in  RO_NO  bank-1 RO outputs, asynchronous to clk.
- ro_en  out  1  RO bank enable.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when response is complete.
- response  out  RESP_BITS  response bits; bit k corresponds to offset k.
- tie_mask  out  RESP_BITS  bit k set when counts were equal for offset k.
- last_cnt0  out  CNT_W  bank-0 count of the most recent window.
- last_cnt1  out  CNT_W  bank-1 count of the most recent window.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, including ro_en, busy, done, response, tie_mask, last_cnt0 and last_cnt1.
  - Counters, bit index, synchronisers and latched challenges are cleared.
- Reset asserted mid-operation aborts the run immediately; no done pulse is issued.
- Select: for bit k, sel0 = chall0_lat + k and sel1 = chall1_lat + k, modulo RO_NO (wraps at RO_NO-1 -> 0).
- Input path: the selected RO bit passes through a 2-flop synchroniser, then a rising-edge detector (sync_q & ~sync_q_d), per bank.
- FSM states:
  - IDLE: busy=0, ro_en=0.
    - start=1 latches chall0/chall1, sets k=0, clears response and tie_mask, then goes to SETTLE with busy=1.
  - SETTLE: ro_en=1; counters held at 0; lasts exactly SETTLE_CYC cycles; then COUNT.
  - COUNT: ro_en=1.
    - Each edge-detect pulse increments its counter; counters saturate at 2**CNT_W-1 and never wrap.
    - Lasts exactly WIN_CYC cycles; then COMPARE.
  - COMPARE (1 cycle): ro_en=0.
    - response[k] = (cnt0 > cnt1).
    - tie_mask[k] = (cnt0 == cnt1); a tie gives response[k]=0.
    - last_cnt0/last_cnt1 take the counts.
    - If k == RESP_BITS-1, go to DONE; otherwise k++, counters and synchronisers are cleared, and the FSM goes to SETTLE.
  - DONE (1 cycle): done=1, busy stays 1; next state IDLE with busy=0.
- Latency: start accepted at cycle 0; done high at cycle RESP_BITS*(SETTLE_CYC+WIN_CYC+1)+1.
- start while busy is ignored; no queuing.
- start held high through DONE is accepted again on the first IDLE cycle.
- response, tie_mask and last_cnt* hold their values after done until the next accepted start.
- An edge-detect pulse counts only if it occurs while in COUNT; pulses arising from transitions during SETTLE are discarded.
- chall0/chall1 changes after acceptance have no effect.

Test Plan:
- Common configuration: RO_NO=4, SEL_W=2, CNT_W=8, WIN_CYC=16, SETTLE_CYC=2, RESP_BITS=2.
- Basic response: ro_out0 all bits toggling every 2 clk (period 4), ro_out1 every 4 clk (period 8); chall0=0, chall1=0, start pulse.
  - Required: done at cycle 2*(2+16+1)+1=39.
  - Required: response=2'b11, tie_mask=0, last_cnt0=4, last_cnt1=2.
- Per-index selection with wrap: chall0=3, chall1=1.
  - ro_out0[3] period 8, ro_out0[0] period 4.
  - ro_out1[1] period 4, ro_out1[2] period 8.
  - Required: response=2'b10, proving offset k=1 selects index 0 (wrap) and index 2.
- Tie: identical period-4 waveforms on both banks.
  - Required: response=0, tie_mask=2'b11, last_cnt0=last_cnt1=4.
- Saturation: CNT_W=2, ro_out0 period 2 clk.
  - Required: last_cnt0=3 with no wrap; response bit is 1 when ro_out1 is static.
- Busy/start: a second start during COUNT is ignored (single done pulse). Then start held high continuously: the second run begins the cycle after DONE.
- Reset mid-run: rst=0 in COUNT of bit 0.
  - Required: all outputs 0 immediately (asynchronous), no done pulse.
  - Required: after release a fresh start completes normally in 39 cycles.
